// File: rtl/decrypt_v2_pkg.sv
// Shared constants, state encoding and PRESENT-80 S-box / key-schedule helpers
// for the iterative decryptor.
package decrypt_v2_pkg;

  localparam int unsigned NK     = 80;
  localparam int unsigned NB     = 64;
  localparam int unsigned ROUNDS = 31;
  localparam int unsigned IdxW   = 5;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(ROUNDS);

  typedef enum logic [2:0] {
    StIdle,
    StKexp,
    StDec,
    StDone,
    StRet
  } state_e;

  // Nibble i of each table holds S[i] (resp. S^-1[i]).
  localparam logic [63:0] SboxTable    = 64'h21748FE3DA09B65C;
  localparam logic [63:0] InvSboxTable = 64'hA970364BD21C8FE5;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SboxTable[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    return InvSboxTable[{x, 2'b00} +: 4];
  endfunction

  // K_{i+1} from K_i: rotate left 61, S-box top nibble, mix in round counter.
  function automatic logic [NK-1:0] key_schedule(input logic [NK-1:0] key,
                                                 input logic [IdxW-1:0] idx);
    logic [NK-1:0] r;
    r            = {key[18:0], key[NK-1:19]};
    r[NK-1 -: 4] = sbox(r[NK-1 -: 4]);
    r[19:15]     = r[19:15] ^ idx;
    return r;
  endfunction

  // K_i from K_{i+1}: undo the three steps above in reverse order.
  function automatic logic [NK-1:0] inv_key_schedule(input logic [NK-1:0] key,
                                                     input logic [IdxW-1:0] idx);
    logic [NK-1:0] r;
    r            = key;
    r[19:15]     = r[19:15] ^ idx;
    r[NK-1 -: 4] = inv_sbox(r[NK-1 -: 4]);
    return {r[NK-20:0], r[NK-1:NK-19]};
  endfunction

endpackage

// File: rtl/decrypt_v2_inv_round.sv
// One combinational PRESENT inverse round: derives K_idx from K_{idx+1} and
// applies invP, invS and the round-key XOR.
module decrypt_v2_inv_round
  import decrypt_v2_pkg::*;
(
  input  logic [NB-1:0]   s_i,
  input  logic [NK-1:0]   kr_i,
  input  logic [IdxW-1:0] idx_i,
  output logic [NB-1:0]   s_o,
  output logic [NK-1:0]   kr_o
);

  logic [NB-1:0] perm;
  logic [NB-1:0] subs;

  // Forward P sends bit j to 16*j mod 63; pull each bit back from there.
  always_comb begin
    perm = '0;
    for (int j = 0; j < 63; j++) begin
      perm[j] = s_i[(16 * j) % 63];
    end
    perm[63] = s_i[63];
  end

  always_comb begin
    subs = '0;
    for (int n = 0; n < 16; n++) begin
      subs[4*n +: 4] = inv_sbox(perm[4*n +: 4]);
    end
  end

  assign kr_o = inv_key_schedule(kr_i, idx_i);
  assign s_o  = subs ^ kr_o[NK-1 -: NB];

endmodule

// File: rtl/decrypt_v2.sv
// Iterative PRESENT-80 decryptor with a 4-phase req/ack handshake.
// Optional last-key cache enabled by defining DECRYPT_KEY_CACHE_EN.
module decrypt_v2
  import decrypt_v2_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [NK-1:0] k,
  input  logic [NB-1:0] c,
  input  logic          req,
  output logic [NB-1:0] m,
  output logic          ack
);

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [NB-1:0]   s_q, s_d;
  logic [NK-1:0]   kr_q, kr_d;
  logic [NB-1:0]   m_q, m_d;
  logic            ack_q, ack_d;

  logic [NK-1:0]   kr_fwd;
  logic [NB-1:0]   s_inv;
  logic [NK-1:0]   kr_inv;

`ifdef DECRYPT_KEY_CACHE_EN
  logic [NK-1:0]   kc_q, kc_d;
  logic [NK-1:0]   k32_q, k32_d;
  logic            kvld_q, kvld_d;
  logic            cache_hit;

  assign cache_hit = kvld_q && (k == kc_q);
`endif

  decrypt_v2_inv_round u_inv_round (
    .s_i   (s_q),
    .kr_i  (kr_q),
    .idx_i (idx_q),
    .s_o   (s_inv),
    .kr_o  (kr_inv)
  );

  assign kr_fwd = key_schedule(kr_q, idx_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    s_d     = s_q;
    kr_d    = kr_q;
    m_d     = m_q;
    ack_d   = ack_q;
`ifdef DECRYPT_KEY_CACHE_EN
    kc_d    = kc_q;
    k32_d   = k32_q;
    kvld_d  = kvld_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req) begin
`ifdef DECRYPT_KEY_CACHE_EN
          if (cache_hit) begin
            kr_d    = k32_q;
            s_d     = c ^ k32_q[NK-1 -: NB];
            idx_d   = LastIdx;
            state_d = StDec;
          end else begin
            kr_d    = k;
            s_d     = c;
            idx_d   = IdxW'(1);
            state_d = StKexp;
          end
`else
          kr_d    = k;
          s_d     = c;
          idx_d   = IdxW'(1);
          state_d = StKexp;
`endif
        end
      end
      StKexp: begin
        if (!req) begin
          idx_d   = '0;
          state_d = StIdle;
        end else begin
          kr_d = kr_fwd;
          if (idx_q == LastIdx) begin
            // kr_fwd is K32 here: whiten with it and start the inverse rounds.
            s_d     = s_q ^ kr_fwd[NK-1 -: NB];
            state_d = StDec;
`ifdef DECRYPT_KEY_CACHE_EN
            kc_d    = k;
            k32_d   = kr_fwd;
            kvld_d  = 1'b1;
`endif
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StDec: begin
        if (!req) begin
          idx_d   = '0;
          state_d = StIdle;
        end else begin
          s_d   = s_inv;
          kr_d  = kr_inv;
          idx_d = idx_q - IdxW'(1);
          if (idx_q == IdxW'(1)) begin
            m_d     = s_inv;
            ack_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (!req) begin
          ack_d   = 1'b0;
          state_d = StRet;
        end
      end
      StRet: begin
        // Forces a pass through idle so a new request must be sampled afresh.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      s_q     <= '0;
      kr_q    <= '0;
      m_q     <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      kr_q    <= kr_d;
      m_q     <= m_d;
      ack_q   <= ack_d;
    end
  end

`ifdef DECRYPT_KEY_CACHE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kc_q   <= '0;
      k32_q  <= '0;
      kvld_q <= 1'b0;
    end else begin
      kc_q   <= kc_d;
      k32_q  <= k32_d;
      kvld_q <= kvld_d;
    end
  end
`endif

  assign m   = m_q;
  assign ack = ack_q;

endmodule

// File: tb/tb_decrypt_v2.sv
// Scoreboard bench for decrypt_v2: directed PRESENT-80 vectors, abort, async
// reset and an encrypt/decrypt round trip against a local encryptor model.
module tb_decrypt_v2;

`ifdef DECRYPT_KEY_CACHE_EN
  localparam bit CacheEn = 1'b1;
`else
  localparam bit CacheEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [79:0] k;
  logic [63:0] c;
  logic        req;
  logic [63:0] m;
  logic        ack;

  typedef struct {
    logic [63:0] m;
    int          edge_no;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic ack_prev = 1'b0;

  // Model of the optional key cache, used only to predict latency.
  logic [79:0] ck = '0;
  logic        cvld = 1'b0;

  decrypt_v2 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .k     (k),
    .c     (c),
    .req   (req),
    .m     (m),
    .ack   (ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] tb_sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
      4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
      4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
      4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
    endcase
  endfunction

  function automatic logic [63:0] present_enc(input logic [79:0] key, input logic [63:0] pt);
    logic [63:0] s;
    logic [63:0] t;
    logic [79:0] kk;
    logic [4:0]  rr;
    s  = pt;
    kk = key;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ kk[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = tb_sbox(s[4*n +: 4]);
      t = '0;
      for (int j = 0; j < 63; j++) t[(16 * j) % 63] = s[j];
      t[63] = s[63];
      s  = t;
      kk = {kk[18:0], kk[79:19]};
      kk[79:76] = tb_sbox(kk[79:76]);
      rr = 5'(r);
      kk[19:15] = kk[19:15] ^ rr;
    end
    return s ^ kk[79:16];
  endfunction

  function automatic int exp_lat(input logic [79:0] kk);
    return (CacheEn && cvld && (kk == ck)) ? 31 : 62;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (ack && !ack_prev) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack m=%h", m);
      end else begin
        mon_e = sbq.pop_front();
        if (m !== mon_e.m) begin
          errors++;
          $display("FAIL result got=%h want=%h", m, mon_e.m);
        end
        checks++;
        if (cyc != mon_e.edge_no) begin
          errors++;
          $display("FAIL ack_latency got_edge=%0d want_edge=%0d", cyc, mon_e.edge_no);
        end
      end
    end
    ack_prev <= ack;
  end

  task automatic do_op(input logic [79:0] kk, input logic [63:0] cc, input logic [63:0] mm);
    int   lat;
    int   n;
    exp_t e;
    @(negedge clk);
    k   = kk;
    c   = cc;
    req = 1'b1;
    lat = exp_lat(kk);
    e.m       = mm;
    e.edge_no = cyc + 1 + lat;
    sbq.push_back(e);
    n = 0;
    while (!ack && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ack) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout got=0 want=1");
      if (sbq.size() != 0) void'(sbq.pop_back());
    end
    if (lat == 62) begin
      ck   = kk;
      cvld = 1'b1;
    end
    req = 1'b0;
    @(negedge clk);
    chk("ack_fall", {63'b0, ack}, 64'd0);
    @(negedge clk);
  endtask

  logic [79:0] rk;
  logic [63:0] rp;

  initial begin
    rst_n = 1'b0;
    k     = '0;
    c     = '0;
    req   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ack", {63'b0, ack}, 64'd0);
    chk("reset_m", m, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(80'h0, 64'h5579C1387B228445, 64'h0);
    do_op({80{1'b1}}, 64'h3333DCD3213210D2, {64{1'b1}});
    repeat (3) @(negedge clk);
    do_op({80{1'b1}}, 64'h3333DCD3213210D2, {64{1'b1}});

    // Abort at edge 40 (inside the inverse rounds); no result may appear.
    @(negedge clk);
    k   = 80'h0;
    c   = 64'hA112FFC72F68417B;
    req = 1'b1;
    if (exp_lat(k) == 62) begin
      ck   = k;
      cvld = 1'b1;
    end
    repeat (40) @(negedge clk);
    req = 1'b0;
    repeat (70) @(negedge clk);
    chk("abort_ack", {63'b0, ack}, 64'd0);
    chk("abort_m_held", m, {64{1'b1}});
    do_op(80'h0, 64'h5579C1387B228445, 64'h0);

    // Async reset in the middle of an operation.
    do_op({80{1'b1}}, 64'h3333DCD3213210D2, {64{1'b1}});
    @(negedge clk);
    k   = {80{1'b1}};
    c   = 64'hE72C46C0F5945049;
    req = 1'b1;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ack", {63'b0, ack}, 64'd0);
    chk("async_rst_m", m, 64'd0);
    cvld = 1'b0;
    req  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op({80{1'b1}}, 64'hE72C46C0F5945049, 64'h0);

    for (int i = 0; i < 300; i++) begin
      rk = {$urandom(), $urandom(), 16'($urandom())};
      rp = {$urandom(), $urandom()};
      do_op(rk, present_enc(rk, rp), rp);
    end

    // Same key back to back, then a different key.
    do_op(80'h0, 64'h5579C1387B228445, 64'h0);
    do_op(80'h0, 64'hA112FFC72F68417B, {64{1'b1}});
    do_op({80{1'b1}}, 64'h3333DCD3213210D2, {64{1'b1}});

    repeat (5) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL pending_results got=%0d want=0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
